// File: rtl/axo_pkg.sv
// Shared definitions for the axo register file family.
// Optional build macro used by axo_regfile_mp: AXO_REGFILE_BYPASS_EN.
package axo_pkg;

    // Architectural register counts for the two supported base ISAs.
    localparam int RV32I_NREG = 32;
    localparam int RV32E_NREG = 16;

    // Register file control state: normal operation or sequential scrub.
    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } axo_rf_state_t;

endpackage

// File: rtl/axo_rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register.
// Allocation sets a bit, writeback clears it; allocation wins a same-cycle
// collision. Bit 0 (x0) is never busy. flush holds every bit at 0.
module axo_rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_rd,
    input  logic            we0,
    input  logic [AW-1:0]   rd0,
    input  logic            we1,
    input  logic [AW-1:0]   rd1,
    output logic [NREG-1:0] busy
);

    // Per-register set/clear with allocation taking priority over writeback.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (alloc_en && (alloc_rd == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if ((we0 && (rd0 == AW'(i))) || (we1 && (rd1 == AW'(i)))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/axo_regfile_mp.sv
// Multi-port integer register file with busy scoreboard and clear engine.
// Storage has no reset; it is zeroed by a sequential scrub (x1..xNREG-1)
// after reset or on clear_req, so the array can map to distributed RAM.
// Build macro AXO_REGFILE_BYPASS_EN: forward same-cycle write data to reads.
//
// Handshake: clear_req is taken only while ready=1 (IDLE); once accepted,
// ready stays low for exactly NREG-1 cycles while the scrub runs, and all
// writes, allocations and read data are suppressed during that time.
module axo_regfile_mp
    import axo_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = RV32I_NREG,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic [NREAD*AW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] dout,
    input  logic [AW-1:0]         rd0,
    input  logic [AW-1:0]         rd1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [XLEN-1:0]       din0,
    input  logic [XLEN-1:0]       din1,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_rd,
    output logic [NREG-1:0]       busy,
    output logic                  state_dbg
);

    axo_rf_state_t   state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] mem [NREG];
    logic            wr_ok;

    // Writes and allocations only take effect in IDLE when no scrub is starting.
    assign wr_ok     = (state == RF_IDLE) && !clear_req;
    assign ready     = (state == RF_IDLE);
    assign state_dbg = (state == RF_CLEAR);

    // Control FSM: walk clr_idx from 1 to NREG-1, then return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_idx <= AW'(1);
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clear_req) begin
                        state   <= RF_CLEAR;
                        clr_idx <= AW'(1);
                    end
                end
                RF_CLEAR: begin
                    if (clr_idx == AW'(NREG - 1)) begin
                        state <= RF_IDLE;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                default: state <= RF_CLEAR;
            endcase
        end
    end

    // Storage: scrub writes during CLEAR, else two write ports with port 1 last.
    always_ff @(posedge clk) begin
        if (!rst && (state == RF_CLEAR)) begin
            mem[clr_idx] <= '0;
        end else if (!rst && wr_ok) begin
            if (we0 && (rd0 != '0)) mem[rd0] <= din0;
            if (we1 && (rd1 != '0)) mem[rd1] <= din1;
        end
    end

    axo_rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (!wr_ok),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .we0      (we0),
        .rd0      (rd0),
        .we1      (we1),
        .rd1      (rd1),
        .busy     (busy)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   ridx;
        logic [XLEN-1:0] rdata;

        assign ridx = rs[k*AW +: AW];
        assign dout[k*XLEN +: XLEN] = rdata;

        // Combinational read: x0 and scrub cycles read 0, optional forwarding.
        always_comb begin
            rdata = '0;
            if ((state == RF_IDLE) && (ridx != '0)) begin
                rdata = mem[ridx];
`ifdef AXO_REGFILE_BYPASS_EN
                if (wr_ok && we1 && (rd1 == ridx)) begin
                    rdata = din1;
                end else if (wr_ok && we0 && (rd0 == ridx)) begin
                    rdata = din0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_axo_regfile_mp.sv
// Self-checking bench for axo_regfile_mp (NREG=32/NREAD=2 and NREG=16/NREAD=1).
module tb_axo_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;

    // NREG=32, NREAD=2 instance
    logic        clear_req;
    logic        ready;
    logic [9:0]  rs;
    logic [63:0] dout;
    logic [4:0]  rd0, rd1, alloc_rd;
    logic        we0, we1, alloc_en;
    logic [31:0] din0, din1;
    logic [31:0] busy;
    logic        dbg;

    // NREG=16, NREAD=1 instance
    logic        s_clear_req;
    logic        s_ready;
    logic [3:0]  s_rs;
    logic [31:0] s_dout;
    logic [3:0]  s_rd0, s_rd1, s_alloc_rd;
    logic        s_we0, s_we1, s_alloc_en;
    logic [31:0] s_din0, s_din1;
    logic [15:0] s_busy;
    logic        s_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural contents, busy set, remaining scrub cycles.
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    int          m_left;

    always #5 clk = ~clk;

    axo_regfile_mp #(.XLEN(32), .NREG(32), .NREAD(2)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready),
        .rs(rs), .dout(dout), .rd0(rd0), .rd1(rd1), .we0(we0), .we1(we1),
        .din0(din0), .din1(din1), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .busy(busy), .state_dbg(dbg)
    );

    axo_regfile_mp #(.XLEN(32), .NREG(16), .NREAD(1)) dut16 (
        .clk(clk), .rst(rst), .clear_req(s_clear_req), .ready(s_ready),
        .rs(s_rs), .dout(s_dout), .rd0(s_rd0), .rd1(s_rd1), .we0(s_we0), .we1(s_we1),
        .din0(s_din0), .din1(s_din1), .alloc_en(s_alloc_en), .alloc_rd(s_alloc_rd),
        .busy(s_busy), .state_dbg(s_dbg)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (m_left > 0 || idx == 5'd0) return 32'h0;
`ifdef AXO_REGFILE_BYPASS_EN
        if (!clear_req && we1 && rd1 == idx) return din1;
        if (!clear_req && we0 && rd0 == idx) return din0;
`endif
        return m_mem[idx];
    endfunction

    task automatic model_step();
        if (rst || (m_left == 0 && clear_req)) begin
            m_left = 31;
            m_busy = '0;
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            if (we0 && rd0 != 0) m_mem[rd0] = din0;
            if (we1 && rd1 != 0) m_mem[rd1] = din1;
            if (we0) m_busy[rd0] = 1'b0;
            if (we1) m_busy[rd1] = 1'b0;
            if (alloc_en) m_busy[alloc_rd] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 0; we0 = 0; we1 = 0; alloc_en = 0;
        rd0 = 0; rd1 = 0; alloc_rd = 0; din0 = 0; din1 = 0; rs = 0;
        s_clear_req = 0; s_we0 = 0; s_we1 = 0; s_alloc_en = 0;
        s_rd0 = 0; s_rd1 = 0; s_alloc_rd = 0; s_din0 = 0; s_din1 = 0; s_rs = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ready"}, {63'd0, ready}, {63'd0, m_left == 0});
        check({tag, "_busy"}, {32'd0, busy}, {32'd0, m_busy});
        for (int k = 0; k < 2; k++) begin
            check({tag, "_dout"}, {32'd0, dout[k*32 +: 32]}, {32'd0, exp_read(rs[k*5 +: 5])});
        end
    endtask

    initial begin
        idle_inputs();
        m_left = 0;
        m_busy = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;

        // Reset pulse: ready low 31 cycles (15 for NREG=16), outputs 0.
        rst = 1;
        tick();
        rst = 0;
        rs = {5'd3, 5'd17};
        s_rs = 4'd5;
        for (int i = 0; i < 31; i++) begin
            #1;
            check("rst_ready", {63'd0, ready}, 64'd0);
            check("rst_busy", {32'd0, busy}, 64'd0);
            check("rst_dout", dout, 64'd0);
            check("rst16_ready", {63'd0, s_ready}, {63'd0, i >= 15});
            tick();
        end
        check("rst_ready_rise", {63'd0, ready}, 64'd1);
        check("rst_dout_after", dout, 64'd0);

        // Dual write to x5: port 1 wins.
        we0 = 1; we1 = 1; rd0 = 5; rd1 = 5; din0 = 32'h1111_1111; din1 = 32'h2222_2222;
        tick();
        idle_inputs();
        rs = {5'd0, 5'd5};
        #1;
        check("dual_wr", {32'd0, dout[31:0]}, 64'h2222_2222);

        // Write to x0 is discarded and x0 never becomes busy.
        we0 = 1; rd0 = 0; din0 = 32'hDEAD_BEEF; alloc_en = 1; alloc_rd = 0;
        tick();
        idle_inputs();
        #1;
        check("x0_read", {32'd0, dout[31:0]}, 64'd0);
        check("x0_busy", {63'd0, busy[0]}, 64'd0);

        // Alloc x7, write it two cycles later.
        alloc_en = 1; alloc_rd = 7;
        tick();
        idle_inputs();
        check("sb_busy7_c1", {63'd0, busy[7]}, 64'd1);
        tick();
        check("sb_busy7_c2", {63'd0, busy[7]}, 64'd1);
        we0 = 1; rd0 = 7; din0 = 32'h55;
        tick();
        idle_inputs();
        rs = {5'd7, 5'd0};
        #1;
        check("sb_busy7_done", {63'd0, busy[7]}, 64'd0);
        check("sb_x7_data", {32'd0, dout[63:32]}, 64'h55);

        // Same-cycle alloc + write of x9: alloc wins, data still written.
        alloc_en = 1; alloc_rd = 9; we1 = 1; rd1 = 9; din1 = 32'h9999;
        tick();
        idle_inputs();
        rs = {5'd9, 5'd9};
        #1;
        check("sb_busy9", {63'd0, busy[9]}, 64'd1);
        check("sb_x9_data", dout, {32'h9999, 32'h9999});

        // Read-during-write of x4.
        we0 = 1; rd0 = 4; din0 = 32'h1234; rs = {5'd0, 5'd4};
        #1;
`ifdef AXO_REGFILE_BYPASS_EN
        check("bypass_x4", {32'd0, dout[31:0]}, 64'h1234);
`else
        check("nobypass_x4", {32'd0, dout[31:0]}, 64'h0);
`endif
        tick();
        idle_inputs();
        rs = {5'd0, 5'd4};
        #1;
        check("x4_after", {32'd0, dout[31:0]}, 64'h1234);

        // Runtime scrub on the NREG=16 instance.
        s_we0 = 1; s_rd0 = 3; s_din0 = 32'hA5;
        tick();
        s_we0 = 0; s_rs = 3;
        #1;
        check("scrub_pre_x3", {32'd0, s_dout}, 64'hA5);
        s_clear_req = 1;
        tick();
        s_clear_req = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 7) begin
                s_we1 = 1; s_rd1 = 3; s_din1 = 32'h77;
            end
            #1;
            check("scrub_ready", {63'd0, s_ready}, 64'd0);
            check("scrub_dout", {32'd0, s_dout}, 64'd0);
            check("scrub_busy", {48'd0, s_busy}, 64'd0);
            tick();
            s_we1 = 0;
        end
        check("scrub_ready_rise", {63'd0, s_ready}, 64'd1);
        check("scrub_x3", {32'd0, s_dout}, 64'd0);

        // Scrub on the main instance interrupted by reset.
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int i = 0; i < 5; i++) begin
            check_all("clr");
            tick();
        end
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            rs = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            #1;
            check_all("rst_mid");
            tick();
        end
        check("rst_mid_ready", {63'd0, ready}, 64'd1);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we0       = 1'($urandom_range(0, 1));
            we1       = 1'($urandom_range(0, 1));
            rd0       = 5'($urandom_range(0, 31));
            rd1       = ($urandom_range(0, 3) == 0) ? rd0 : 5'($urandom_range(0, 31));
            din0      = $urandom;
            din1      = $urandom;
            alloc_en  = ($urandom_range(0, 2) == 0);
            alloc_rd  = ($urandom_range(0, 3) == 0) ? rd1 : 5'($urandom_range(0, 31));
            clear_req = ($urandom_range(0, 99) == 0);
            rs        = {5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0) ? rd0 : 5'($urandom_range(0, 31))};
            #1;
            check_all("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axo_regfile_mp.md
Name: axo_regfile_mp

Overview:
- Parametrised successor to the single-write integer register file: configurable register count (RV32I/RV32E), XLEN, read-port count and two write ports.
- Adds per-register busy scoreboard bits for pipelined/out-of-order writeback.
- Adds a sequential clear engine, so storage carries no reset and maps to distributed RAM.
- Sits between decode (reads, allocation) and writeback (writes) in the core.

Parameters:
- XLEN, 32, register width in bits.
- NREG, 32, architectural register count; legal values 16 (RV32E) or 32.
- NREAD, 2, number of combinational read ports, 1..4.
- AW (localparam), $clog2(NREG), register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_req  in  1  request a runtime scrub of all registers; sampled only when ready=1.
- ready  out  1  high when idle; low while clearing.
- rs  in  NREAD*AW  packed read indices; port k uses bits [k*AW +: AW].
- dout  out  NREAD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
- rd0, rd1  in  AW each  write indices for write ports 0 and 1.
- we0, we1  in  1 each  write enables.
- din0, din1  in  XLEN each  write data.
- alloc_en  in  1  mark register alloc_rd busy.
- alloc_rd  in  AW  register index to mark busy.
- busy  out  NREG  scoreboard bits; bit 0 is always 0.

Behaviour:
- Sync reset: rst=1 at a rising edge sets state=CLEAR, clr_idx=1, busy=0, ready=0.
  - Storage is not reset directly; it is zeroed by the CLEAR sequence.
- States:
  - IDLE: ready=1. If clear_req=1, go to CLEAR with clr_idx=1. Otherwise perform writes.
  - CLEAR: each cycle write 0 to data[clr_idx] and increment clr_idx. When clr_idx==NREG-1, that location is written and the state returns to IDLE. A clear takes exactly NREG-1 cycles; ready rises on the following cycle.
- During CLEAR:
  - we0, we1 and alloc_en are ignored.
  - All dout are forced to 0.
  - busy is held at 0.
- rst asserted mid-CLEAR restarts the sequence at clr_idx=1.
- Reads:
  - Combinational, zero latency.
  - Index 0 always returns 0.
  - An index >= NREG (only possible when NREG=16 with a wider source) is illegal; dout is then don't-care.
- Writes (IDLE only):
  - Registered on the rising edge.
  - A write to index 0 is discarded.
  - If we0 and we1 both target the same rd, port 1 wins.
- Scoreboard (IDLE only):
  - alloc_en sets busy[alloc_rd].
  - A write clears busy[rd] for each active write port.
  - If alloc and write hit the same register in the same cycle, alloc wins (busy=1, data updated).
  - alloc_rd=0 is ignored.
- Read-during-write: without bypass, dout shows the old value until the edge.

Optional Feature:
- Macro: AXO_REGFILE_BYPASS_EN.
- Defined: a read of index r with an active same-cycle write to r (r != 0, IDLE) returns that write's din combinationally. Port 1 has priority over port 0, matching the write rule.
- Undefined: pure array read; the old value is visible until the clock edge.

Decomposition:
- Shared package axo_pkg holds:
  - RV32I_NREG=32 and RV32E_NREG=16 constants.
  - enum typedef axo_rf_state_t {RF_IDLE, RF_CLEAR}.
- One natural sub-module: axo_rf_scoreboard (the busy-bit vector with alloc/clear priority), instantiated once.
- The storage array and read muxes stay in the top module.

Test Plan:
- Reset, NREG=32: pulse rst for one cycle. ready must stay 0 for 31 cycles and then go to 1. All dout must read 0 and busy must be 0.
- Dual-write conflict: we0=we1=1, rd0=rd1=5, din0=0x1111_1111, din1=0x2222_2222. The next cycle, reading rs=5 must return 0x2222_2222.
- Write to x0: we0=1, rd0=0, din0=0xDEAD_BEEF. A read of x0 must return 0, and busy[0] must remain 0.
- Scoreboard: alloc x7, then write x7 with 0x55 two cycles later. busy[7] must be 1 for exactly those 2 cycles and 0 afterwards. Same-cycle alloc+write of x9 must leave busy[9]=1 with data=write value.
- Runtime scrub, NREG=16: write x3=0xA5, then assert clear_req. ready must be low for 15 cycles; a write attempted mid-clear is ignored; afterwards x3 reads 0.
- Bypass, with AXO_REGFILE_BYPASS_EN: write x4=0x1234 with rs=4 in the same cycle. dout must equal 0x1234 combinationally. Without the macro, dout shows the prior value (0).
